// File: rtl/apb4_ram_completer.sv
`timescale 1ns/1ps
// APB4 completer fronting a word-organised RAM with byte-lane writes and PSLVERR on bad accesses.
// Latency: PREADY rises WAIT_STATES+1 cycles after the setup edge; the transfer completes on the next access edge.
// Backpressure: PREADY is held low for WAIT_STATES access cycles; dropping PSEL/PENABLE mid-transfer aborts it.
module apb4_ram_completer #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int APB_STRB_WIDTH = APB_DATA_WIDTH / 8,
    parameter int DEPTH          = 256,
    parameter int WAIT_STATES    = 0,
    parameter int SECURE_BASE    = 128
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [APB_DATA_WIDTH-1:0] PWDATA,
    input  logic [APB_STRB_WIDTH-1:0] PSTRB,
    input  logic [2:0]                PPROT,
    output logic                      PREADY,
    output logic [APB_DATA_WIDTH-1:0] PRDATA,
    output logic                      PSLVERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      pready_q;
    logic                      pslverr_q;
    logic [APB_DATA_WIDTH-1:0] prdata_q;

    // Transfer context captured at the setup edge; the bus is not looked at again
    // for address/data/strobe/direction until the next setup phase.
    logic                      pwrite_q;
    logic [IDX_W-1:0]          idx_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [APB_STRB_WIDTH-1:0] strb_q;
    logic                      err_q;

    // Storage is deliberately left out of reset so it survives a bus reset.
    logic [APB_DATA_WIDTH-1:0] ram_q [DEPTH];

    logic                      setup_phase;
    logic                      access_phase;
    logic [APB_ADDR_WIDTH-1:0] word_addr;
    logic                      misaligned_d;
    logic                      range_err_d;
    logic                      secure_err_d;
    logic                      err_d;
    logic [IDX_W-1:0]          idx_d;
    logic [IDX_W-1:0]          rd_idx;
    logic [APB_DATA_WIDTH-1:0] rd_word;
    logic                      wr_commit;
    logic                      prot_unused;

    assign setup_phase  = PSEL & ~PENABLE;
    assign access_phase = PSEL & PENABLE;

    // Only the secure/non-secure bit of PPROT affects this completer.
    assign prot_unused  = PPROT[2] ^ PPROT[0];

    // Error classification happens once, at setup, on the full-width word address
    // so that out-of-range addresses cannot alias into the array.
    assign word_addr    = PADDR >> 2;
    assign misaligned_d = |PADDR[1:0];
    assign range_err_d  = (word_addr >= APB_ADDR_WIDTH'(DEPTH));
    assign secure_err_d = PPROT[1] & (word_addr >= APB_ADDR_WIDTH'(SECURE_BASE));
    assign err_d        = misaligned_d | range_err_d | secure_err_d;
    assign idx_d        = word_addr[IDX_W-1:0];

    // Zero-wait reads fetch at the setup edge from the live address; with wait
    // states the fetch happens on the last wait edge from the captured index.
    assign rd_idx  = (state_q == ST_IDLE) ? idx_d : idx_q;
    assign rd_word = ram_q[rd_idx];

    // A write lands only on a genuine completion of an error-free write transfer.
    assign wr_commit = (state_q == ST_READY) & access_phase & pwrite_q & ~err_q & ~PRESET;

    // Transfer sequencer: IDLE -> (WAIT) -> READY -> IDLE, all bus outputs registered.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            pwrite_q  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (setup_phase) begin
                        pwrite_q <= PWRITE;
                        idx_q    <= idx_d;
                        wdata_q  <= PWDATA;
                        strb_q   <= PSTRB;
                        err_q    <= err_d;
                        if (WAIT_STATES == 0) begin
                            state_q   <= ST_READY;
                            pready_q  <= 1'b1;
                            pslverr_q <= err_d;
                            if (!PWRITE) begin
                                prdata_q <= err_d ? '0 : rd_word;
                            end
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(WAIT_STATES);
                        end
                    end
                end

                ST_WAIT: begin
                    if (!access_phase) begin
                        // Requester abandoned the transfer.
                        state_q   <= ST_IDLE;
                        cnt_q     <= '0;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q   <= ST_READY;
                        cnt_q     <= '0;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_q;
                        if (!pwrite_q) begin
                            prdata_q <= err_q ? '0 : rd_word;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_READY: begin
                    // Either the transfer completes (access phase) or it is
                    // abandoned; both end in IDLE with the handshake cleared.
                    state_q   <= ST_IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= '0;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write into the array at transfer completion.
    always_ff @(posedge PCLK) begin
        if (wr_commit) begin
            for (int i = 0; i < APB_STRB_WIDTH; i++) begin
                if (strb_q[i]) begin
                    ram_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign PREADY  = pready_q;
    assign PRDATA  = prdata_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_ram_completer.sv
`timescale 1ns/1ps
// Bench for apb4_ram_completer: three instances (0, 3 and 2 wait states) driven by directed transfers.
// A transaction-level model predicts PREADY timing, PSLVERR and PRDATA; one negedge process compares every cycle.
// Reads may carry a hand-computed literal that pins both the model and the DUT.
module tb_apb4_ram_completer;

    localparam int ND = 3;

    logic        PCLK = 1'b0;
    logic        preset  [ND];
    logic        psel    [ND];
    logic        penable [ND];
    logic        pwrite  [ND];
    logic [31:0] paddr   [ND];
    logic [31:0] pwdata  [ND];
    logic [3:0]  pstrb   [ND];
    logic [2:0]  pprot   [ND];
    logic        pready  [ND];
    logic [31:0] prdata  [ND];
    logic        pslverr [ND];

    always #5 PCLK = ~PCLK;

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
        apb4_ram_completer #(
            .APB_ADDR_WIDTH(32),
            .APB_DATA_WIDTH(32),
            .DEPTH(256),
            .WAIT_STATES(WS),
            .SECURE_BASE(128)
        ) u_dut (
            .PCLK    (PCLK),
            .PRESET  (preset[g]),
            .PSEL    (psel[g]),
            .PENABLE (penable[g]),
            .PWRITE  (pwrite[g]),
            .PADDR   (paddr[g]),
            .PWDATA  (pwdata[g]),
            .PSTRB   (pstrb[g]),
            .PPROT   (pprot[g]),
            .PREADY  (pready[g]),
            .PRDATA  (prdata[g]),
            .PSLVERR (pslverr[g])
        );
    end

    // Model state: RAM image per instance and per-cycle output expectations.
    logic [31:0] mdl [ND][256];
    bit          exp_on = 1'b0;
    bit          exp_pready [ND];
    bit          exp_err    [ND];
    bit          exp_chkrd  [ND];
    logic [31:0] exp_rdata  [ND];
    bit          exp_litv   [ND];
    logic [31:0] exp_lit    [ND];
    string       exp_name   [ND];

    int n_chk = 0;
    int n_err = 0;

    // Single compare process, sampling away from the active edge.
    always @(negedge PCLK) begin
        if (exp_on) begin
            for (int d = 0; d < ND; d++) begin
                n_chk++;
                if (pready[d] !== exp_pready[d]) begin
                    n_err++;
                    $display("FAIL %s dut%0d PREADY got %b want %b @%0t", exp_name[d], d, pready[d], exp_pready[d], $time);
                end
                n_chk++;
                if (pslverr[d] !== exp_err[d]) begin
                    n_err++;
                    $display("FAIL %s dut%0d PSLVERR got %b want %b @%0t", exp_name[d], d, pslverr[d], exp_err[d], $time);
                end
                if (exp_chkrd[d]) begin
                    n_chk++;
                    if (prdata[d] !== exp_rdata[d]) begin
                        n_err++;
                        $display("FAIL %s dut%0d PRDATA got %h want %h @%0t", exp_name[d], d, prdata[d], exp_rdata[d], $time);
                    end
                end
                if (exp_litv[d]) begin
                    n_chk++;
                    if (exp_rdata[d] !== exp_lit[d]) begin
                        n_err++;
                        $display("FAIL %s dut%0d model-literal got %h want %h", exp_name[d], d, exp_rdata[d], exp_lit[d]);
                    end
                    n_chk++;
                    if (prdata[d] !== exp_lit[d]) begin
                        n_err++;
                        $display("FAIL %s dut%0d PRDATA-literal got %h want %h", exp_name[d], d, prdata[d], exp_lit[d]);
                    end
                end
            end
        end
    end

    task automatic set_exp(input int d, input bit pr, input bit er, input bit chk,
                           input logic [31:0] rd, input bit litv, input logic [31:0] lit);
        exp_pready[d] = pr;
        exp_err[d]    = er;
        exp_chkrd[d]  = chk;
        exp_rdata[d]  = rd;
        exp_litv[d]   = litv;
        exp_lit[d]    = lit;
    endtask

    task automatic idle(input int d, input int n);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        set_exp(d, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (n) begin
            @(posedge PCLK);
            #1;
        end
    endtask

    // One APB transfer; abort_k >= 0 abandons it in access cycle abort_k
    // (by dropping PSEL, and additionally pulsing reset when use_rst is set).
    task automatic xfer(input int d, input string name, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input int abort_k, input bit use_rst,
                        input bit litv, input logic [31:0] lit);
        int          ws;
        bit          err;
        bit          done;
        logic [31:0] widx;
        logic [31:0] rd;

        ws   = ws_of(d);
        widx = addr / 4;
        err  = (addr % 4 != 0) || (widx >= 256) || (prot[1] && widx >= 128);
        if (err) rd = 32'h0;
        else     rd = mdl[d][widx[7:0]];

        exp_name[d] = name;
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        pprot[d]   = prot;
        set_exp(d, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge PCLK);
        #1;
        // Everything but the handshake is scrambled: only setup-time values count.
        penable[d] = 1'b1;
        pwrite[d]  = ~wr;
        paddr[d]   = ~addr;
        pwdata[d]  = ~wdata;
        pstrb[d]   = ~strb;
        pprot[d]   = ~prot;

        done = 1'b0;
        for (int k = 0; k <= ws && !done; k++) begin
            if (k == abort_k) begin
                psel[d]    = 1'b0;
                penable[d] = 1'b0;
                if (use_rst) preset[d] = 1'b1;
                set_exp(d, 1'b0, 1'b0, use_rst, 32'h0, 1'b0, 32'h0);
                @(posedge PCLK);
                #1;
                preset[d] = 1'b0;
                done = 1'b1;
            end else begin
                set_exp(d, k == ws, (k == ws) && err, (k == ws) && !wr, rd,
                        (k == ws) && litv, lit);
                @(posedge PCLK);
                #1;
            end
        end

        if (!done && wr && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mdl[d][widx[7:0]][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        set_exp(d, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            preset[d]  = 1'b1;
            psel[d]    = 1'b0;
            penable[d] = 1'b0;
            pwrite[d]  = 1'b0;
            paddr[d]   = 32'h0;
            pwdata[d]  = 32'h0;
            pstrb[d]   = 4'h0;
            pprot[d]   = 3'h0;
            exp_name[d] = "reset";
            set_exp(d, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
        end
        exp_on = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        for (int d = 0; d < ND; d++) begin
            preset[d] = 1'b0;
            exp_name[d] = "idle";
            set_exp(d, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        @(posedge PCLK);
        #1;

        // Zero-wait write/read
        xfer(0, "wr10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        idle(0, 1);
        xfer(0, "rd10", 0, 32'h10, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'hDEADBEEF);
        idle(0, 1);

        // Byte strobes, then an all-zero strobe write
        xfer(0, "wr20", 1, 32'h20, 32'h11223344, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        xfer(0, "wr20s5", 1, 32'h20, 32'hAABBCCDD, 4'h5, 3'b000, -1, 0, 0, 32'h0);
        idle(0, 1);
        xfer(0, "rd20", 0, 32'h20, 32'h0, 4'h0, 3'b000, -1, 0, 1, 32'h11BB33DD);
        xfer(0, "wr20s0", 1, 32'h20, 32'hFFFFFFFF, 4'h0, 3'b000, -1, 0, 0, 32'h0);
        xfer(0, "rd20b", 0, 32'h20, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h11BB33DD);
        idle(0, 2);

        // Errors and range/security boundaries
        xfer(0, "rd400", 0, 32'h400, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h0);
        xfer(0, "wr22", 1, 32'h22, 32'h12345678, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        xfer(0, "wr3fc", 1, 32'h3FC, 32'h0000ABCD, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        xfer(0, "rd3fc", 0, 32'h3FC, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h0000ABCD);
        xfer(0, "wr200s", 1, 32'h200, 32'hCAFEF00D, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        xfer(0, "wr200ns", 1, 32'h200, 32'h00000055, 4'hF, 3'b010, -1, 0, 0, 32'h0);
        xfer(0, "rd200ns", 0, 32'h200, 32'h0, 4'hF, 3'b010, -1, 0, 1, 32'h0);
        xfer(0, "rd200s", 0, 32'h200, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'hCAFEF00D);
        xfer(0, "wr1fcns", 1, 32'h1FC, 32'h0BADCAFE, 4'hF, 3'b010, -1, 0, 0, 32'h0);
        xfer(0, "rd1fcns", 0, 32'h1FC, 32'h0, 4'hF, 3'b010, -1, 0, 1, 32'h0BADCAFE);
        idle(0, 1);

        // Back-to-back write then read, no idle cycle
        xfer(0, "b2b_wr0", 1, 32'h0, 32'h00000001, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        xfer(0, "b2b_rd0", 0, 32'h0, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h00000001);
        idle(0, 1);

        // Three wait states
        xfer(1, "ws3_wr10", 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        idle(1, 1);
        xfer(1, "ws3_rd10", 0, 32'h10, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'hDEADBEEF);
        xfer(1, "ws3_rd404", 0, 32'h404, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h0);
        xfer(1, "ws3_wr14", 1, 32'h14, 32'h01020304, 4'h6, 3'b000, -1, 0, 0, 32'h0);
        idle(1, 1);

        // Abort by PSEL drop and by reset, two wait states
        xfer(2, "ws2_wr30", 1, 32'h30, 32'h12345678, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        idle(2, 1);
        xfer(2, "abort_wr30", 1, 32'h30, 32'hFFFF0000, 4'hF, 3'b000, 1, 0, 0, 32'h0);
        idle(2, 1);
        xfer(2, "rd30_a", 0, 32'h30, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h12345678);
        idle(2, 1);
        xfer(2, "rst_wr30", 1, 32'h30, 32'hFFFF0000, 4'hF, 3'b000, 1, 1, 0, 32'h0);
        idle(2, 1);
        xfer(2, "rd30_r", 0, 32'h30, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'h12345678);
        xfer(2, "wr30_ok", 1, 32'h30, 32'hFFFF0000, 4'hF, 3'b000, -1, 0, 0, 32'h0);
        xfer(2, "rd30_ok", 0, 32'h30, 32'h0, 4'hF, 3'b000, -1, 0, 1, 32'hFFFF0000);
        idle(2, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/apb4_ram_completer.md
Name: apb4_ram_completer

Overview:
- APB4 completer (slave) side of the bus: a word-organised RAM answering transfers on PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT.
- Drives PREADY/PRDATA/PSLVERR with a programmable number of wait states.
- Byte-lane writes via PSTRB; PSLVERR on range, alignment and security violations.
- Sits behind the APB bridge as the peripheral the bridge selects.

Parameters:
- APB_ADDR_WIDTH, 32: PADDR width (byte address).
- APB_DATA_WIDTH, 32: PWDATA/PRDATA width; must be a multiple of 8.
- APB_STRB_WIDTH, APB_DATA_WIDTH/8: PSTRB width.
- DEPTH, 256: number of RAM words.
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase (0..15).
- SECURE_BASE, 128: first word index that only secure accesses (PPROT[1]=0) may touch.

Ports:
- PCLK  in  1  clock; all state changes on rising edge.
- PRESET  in  1  asynchronous reset, active-high.
- PSEL  in  1  completer selected.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWDATA  in  APB_DATA_WIDTH  write data.
- PSTRB  in  APB_STRB_WIDTH  write byte-lane enables.
- PPROT  in  3  protection; bit1=non-secure.
- PREADY  out  1  transfer-complete indicator.
- PRDATA  out  APB_DATA_WIDTH  read data.
- PSLVERR  out  1  transfer error.

Behaviour:
- Reset (PRESET=1, takes effect immediately): state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0. RAM contents are not cleared.
- Outputs are all registered.
- States:
  - IDLE: on an edge with PSEL=1 and PENABLE=0 (setup phase), latch PWRITE/PADDR/PWDATA/PSTRB/PPROT and evaluate the error. If WAIT_STATES=0, go READY; otherwise load counter=WAIT_STATES and go WAIT.
  - WAIT: PREADY=0. Each edge with PSEL&PENABLE decrements the counter; at counter==1 go READY.
  - READY: PREADY=1. PRDATA and PSLVERR are valid in the same cycle. At the next edge with PSEL&PENABLE the transfer completes: a write commits, then return to IDLE with PREADY=0 and PSLVERR=0.
- Latency: completion occurs WAIT_STATES+1 cycles after the setup edge. Zero-wait gives the spec-minimum 2-cycle transfer.
- Back-to-back: a setup phase on the cycle right after completion is accepted; no idle cycle is required.
- Error (PSLVERR=1 in READY) when any of these hold:
  - PADDR[1:0]!=0 (misaligned);
  - word index PADDR>>2 >= DEPTH;
  - PPROT[1]=1 and word index >= SECURE_BASE.
- On error: a write leaves the RAM untouched; a read returns PRDATA=0.
- Write: for each lane i with PSTRB[i]=1, update byte i at completion. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Read: PRDATA = RAM[index] loaded on entry to READY. PSTRB is ignored on reads. PRDATA holds its last value outside READY.
- Aborts: if PSEL or PENABLE drops while in WAIT/READY, return to IDLE at that edge. No write occurs, PREADY=0, PSLVERR=0.
- Latched values are used for the whole transfer; bus changes after the setup edge are ignored.
- Reset mid-transfer: immediate IDLE; any pending write is discarded.
- Read of a never-written word returns X in simulation. Benches must write before reading.

Test Plan:
- Zero-wait write/read: WAIT_STATES=0; write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10. Required: PREADY high in the first access cycle of each transfer; PRDATA=0xDEADBEEF, PSLVERR=0.
- Wait states: WAIT_STATES=3; read 0x10. Required: PREADY low for 3 access cycles, high on the 4th with PRDATA=0xDEADBEEF.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD with PSTRB=0x5, then read 0x20. Required: PRDATA=0x11BB33DD.
- Errors:
  - read of 0x400 (index 256 with DEPTH=256): PSLVERR=1, PRDATA=0;
  - write to 0x22 (misaligned): PSLVERR=1;
  - non-secure write (PPROT=3'b010) of 0x55 to 0x200 (index 128): PSLVERR=1, and a later secure read of 0x200 returns its prior value.
- Back-to-back: write 0x1 to 0x0, then a setup for a read of 0x0 in the very next cycle. Required: both complete with no idle cycle and the read returns 0x1.
- Abort/reset: WAIT_STATES=2; write 0xFFFF0000 to 0x30, drop PSEL in the 2nd access cycle. Then repeat and assert PRESET mid-WAIT. Required: in both cases PREADY=0 and 0x30 retains its old value.
